// File: rtl/alu_share_arbiter_pkg.sv
// Shared types and constants for the ALU share arbiter: FSM encoding, ALU select codes
// and default datapath widths matching the single 8-bit ALU.
package alu_share_arbiter_pkg;

    localparam int unsigned DefDataW = 8;
    localparam int unsigned DefSelW  = 3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

    localparam logic [DefSelW-1:0] AluAdd = 3'b000;
    localparam logic [DefSelW-1:0] AluSub = 3'b001;
    localparam logic [DefSelW-1:0] AluOr  = 3'b100;
    localparam logic [DefSelW-1:0] AluNor = 3'b101;
    localparam logic [DefSelW-1:0] AluAnd = 3'b110;
    localparam logic [DefSelW-1:0] AluXor = 3'b111;

endpackage

// File: rtl/alu_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr_i, wrapping
// modulo NumReq. Produces a one-hot grant, its encoded index and an any-valid flag.
module alu_share_arbiter_rr_pick #(
    parameter int unsigned NumReq = 2,
    parameter int unsigned IdW    = 1
) (
    input  logic [NumReq-1:0] req_valid_i,
    input  logic [IdW-1:0]    rr_ptr_i,
    output logic [NumReq-1:0] grant_o,
    output logic [IdW-1:0]    idx_o,
    output logic              any_valid_o
);

    always_comb begin
        int unsigned cand;
        grant_o     = '0;
        idx_o       = '0;
        any_valid_o = 1'b0;
        cand        = 0;
        for (int unsigned off = 0; off < NumReq; off++) begin
            // Modulo keeps candidates in range even for an out-of-range pointer.
            cand = (32'(rr_ptr_i) + off) % NumReq;
            if (!any_valid_o && req_valid_i[cand]) begin
                grant_o[cand] = 1'b1;
                idx_o         = IdW'(cand);
                any_valid_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between NumReq requesters: round-robin accept in IDLE,
// one EXEC cycle with registered operands, then a held valid/ready response in RESP.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int unsigned NumReq = 2,
    parameter int unsigned IdW    = 1,
    parameter int unsigned DataW  = DefDataW,
    parameter int unsigned SelW   = DefSelW
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NumReq-1:0]        req_valid_i,
    output logic [NumReq-1:0]        req_ready_o,
    input  logic [DataW*NumReq-1:0]  req_a_i,
    input  logic [DataW*NumReq-1:0]  req_b_i,
    input  logic [SelW*NumReq-1:0]   req_sel_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [IdW-1:0]           rsp_id_o,
    output logic [DataW-1:0]         rsp_result_o,
    output logic                     rsp_zflag_o,
    output logic [DataW-1:0]         alu_a_o,
    output logic [DataW-1:0]         alu_b_o,
    output logic [SelW-1:0]          alu_sel_o,
    input  logic [DataW-1:0]         alu_result_i,
    input  logic                     alu_zflag_i,
    output logic                     busy_o
);

    state_e              state_q;
    logic [IdW-1:0]      rr_ptr_q;
    logic [DataW-1:0]    alu_a_q, alu_b_q, rsp_result_q;
    logic [SelW-1:0]     alu_sel_q;
    logic [IdW-1:0]      rsp_id_q;
    logic                rsp_valid_q, rsp_zflag_q;

    logic [NumReq-1:0]   grant;
    logic [IdW-1:0]      grant_idx;
    logic                any_valid;

    alu_share_arbiter_rr_pick #(
        .NumReq (NumReq),
        .IdW    (IdW)
    ) u_rr_pick (
        .req_valid_i (req_valid_i),
        .rr_ptr_i    (rr_ptr_q),
        .grant_o     (grant),
        .idx_o       (grant_idx),
        .any_valid_o (any_valid)
    );

    // Gated by rst_ni so no handshake can be signalled while reset is asserted.
    assign req_ready_o  = (rst_ni && state_q == StIdle) ? grant : '0;
    assign busy_o       = (state_q != StIdle);
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_id_o     = rsp_id_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_zflag_o  = rsp_zflag_q;
    assign alu_a_o      = alu_a_q;
    assign alu_b_o      = alu_b_q;
    assign alu_sel_o    = alu_sel_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            rr_ptr_q     <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_zflag_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any_valid) begin
                        alu_a_q   <= req_a_i[grant_idx*DataW +: DataW];
                        alu_b_q   <= req_b_i[grant_idx*DataW +: DataW];
                        alu_sel_q <= req_sel_i[grant_idx*SelW +: SelW];
                        rsp_id_q  <= grant_idx;
                        state_q   <= StExec;
                    end
                end
                StExec: begin
                    rsp_result_q <= alu_result_i;
                    rsp_zflag_q  <= alu_zflag_i;
                    rsp_valid_q  <= 1'b1;
                    state_q      <= StResp;
                end
                StResp: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        rr_ptr_q    <= (rsp_id_q == IdW'(NumReq - 1)) ? '0 : rsp_id_q + 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU on the shared port;
// every expected value is a hand-computed constant.
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [1:0]  req_valid_i;
    logic [1:0]  req_ready_o;
    logic [15:0] req_a_i, req_b_i;
    logic [5:0]  req_sel_i;
    logic        rsp_valid_o, rsp_ready_i;
    logic [0:0]  rsp_id_o;
    logic [7:0]  rsp_result_o;
    logic        rsp_zflag_o;
    logic [7:0]  alu_a_o, alu_b_o, alu_result_i;
    logic [2:0]  alu_sel_o;
    logic        alu_zflag_i;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    alu_share_arbiter #(
        .NumReq (2),
        .IdW    (1),
        .DataW  (8),
        .SelW   (3)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_a_i      (req_a_i),
        .req_b_i      (req_b_i),
        .req_sel_i    (req_sel_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_id_o     (rsp_id_o),
        .rsp_result_o (rsp_result_o),
        .rsp_zflag_o  (rsp_zflag_o),
        .alu_a_o      (alu_a_o),
        .alu_b_o      (alu_b_o),
        .alu_sel_o    (alu_sel_o),
        .alu_result_i (alu_result_i),
        .alu_zflag_i  (alu_zflag_i),
        .busy_o       (busy_o)
    );

    always_comb begin
        alu_result_i = 8'h00;
        unique case (alu_sel_o)
            3'b000:                 alu_result_i = alu_a_o + alu_b_o;
            3'b001, 3'b010, 3'b011: alu_result_i = alu_a_o - alu_b_o;
            3'b100:                 alu_result_i = alu_a_o | alu_b_o;
            3'b101:                 alu_result_i = ~(alu_a_o | alu_b_o);
            3'b110:                 alu_result_i = alu_a_o & alu_b_o;
            default:                alu_result_i = alu_a_o ^ alu_b_o;
        endcase
        alu_zflag_i = (alu_result_i == 8'h00);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] sel);
        req_a_i[id*8 +: 8]   = a;
        req_b_i[id*8 +: 8]   = b;
        req_sel_i[id*3 +: 3] = sel;
    endtask

    // One full transaction with rsp_ready high; starts and ends #1 after an edge in IDLE.
    task automatic do_op(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] sel, input logic [7:0] res, input logic z);
        set_req(id, a, b, sel);
        req_valid_i[id] = 1'b1;
        #1;
        check("op_ready", 32'(req_ready_o), 32'(2'b01 << id));
        tick();
        req_valid_i[id] = 1'b0;
        check("op_busy", 32'(busy_o), 1);
        tick();
        check("op_rsp_valid", 32'(rsp_valid_o), 1);
        check("op_rsp_id", 32'(rsp_id_o), 32'(id));
        check("op_result", 32'(rsp_result_o), 32'(res));
        check("op_zflag", 32'(rsp_zflag_o), 32'(z));
        tick();
        check("op_done", 32'(rsp_valid_o), 0);
    endtask

    task automatic apply_reset();
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    logic [7:0] exp_res [4];
    logic       exp_z   [4];

    initial begin
        rst_ni      = 1'b0;
        req_valid_i = 2'b01;
        req_a_i     = '0;
        req_b_i     = '0;
        req_sel_i   = '0;
        rsp_ready_i = 1'b1;
        #2;
        // Reset values, with a request already pending
        check("rst_ready", 32'(req_ready_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_rsp_valid", 32'(rsp_valid_o), 0);
        check("rst_alu_a", 32'(alu_a_o), 0);
        check("rst_rsp_id", 32'(rsp_id_o), 0);
        check("rst_result", 32'(rsp_result_o), 0);
        req_valid_i = 2'b00;
        tick();
        rst_ni = 1'b1;
        tick();

        // Single request, zero flag cases
        do_op(0, 8'h05, 8'h03, AluAdd, 8'h08, 1'b0);
        do_op(1, 8'h10, 8'h10, AluSub, 8'h00, 1'b1);
        do_op(0, 8'h0F, 8'hF0, AluNor, 8'h00, 1'b1);

        // Simultaneous requests from reset: grants alternate 0,1,0,1
        apply_reset();
        set_req(0, 8'hFF, 8'h01, AluAdd);
        set_req(1, 8'h22, 8'h33, AluAnd);
        exp_res = '{8'h00, 8'h22, 8'h00, 8'h22};
        exp_z   = '{1'b1, 1'b0, 1'b1, 1'b0};
        req_valid_i = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("sim_ready", 32'(req_ready_o), 32'(2'b01 << (i % 2)));
            tick();
            tick();
            check("sim_id", 32'(rsp_id_o), 32'(i % 2));
            check("sim_result", 32'(rsp_result_o), 32'(exp_res[i]));
            check("sim_zflag", 32'(rsp_zflag_o), 32'(exp_z[i]));
            tick();
        end
        req_valid_i = 2'b00;
        tick();

        // Back-pressure with req1 pending; rr_ptr is 0 here
        set_req(0, 8'h30, 8'h0C, AluXor);
        set_req(1, 8'h09, 8'h04, 3'b010);
        rsp_ready_i = 1'b0;
        req_valid_i = 2'b11;
        #1;
        check("bp_grant0", 32'(req_ready_o), 32'h1);
        tick();
        req_valid_i = 2'b10;
        check("bp_exec_ready", 32'(req_ready_o), 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(rsp_valid_o), 1);
            check("bp_result", 32'(rsp_result_o), 32'h3C);
            check("bp_id", 32'(rsp_id_o), 0);
            check("bp_ready", 32'(req_ready_o), 0);
            tick();
        end
        rsp_ready_i = 1'b1;
        check("bp_hs_ready", 32'(req_ready_o), 0);
        tick();
        check("bp_grant1", 32'(req_ready_o), 32'h2);
        tick();
        req_valid_i = 2'b00;
        check("bp_alu_a", 32'(alu_a_o), 32'h09);
        tick();
        check("bp_r1_id", 32'(rsp_id_o), 1);
        check("bp_r1_result", 32'(rsp_result_o), 32'h05);
        tick();

        // Reset during EXEC; move rr_ptr to 1 first
        do_op(0, 8'h01, 8'h02, AluAdd, 8'h03, 1'b0);
        set_req(1, 8'h77, 8'h01, AluOr);
        req_valid_i = 2'b10;
        #1;
        check("mid_grant1", 32'(req_ready_o), 32'h2);
        tick();
        req_valid_i = 2'b00;
        rst_ni = 1'b0;
        #1;
        check("mid_busy", 32'(busy_o), 0);
        check("mid_alu_a", 32'(alu_a_o), 0);
        check("mid_alu_sel", 32'(alu_sel_o), 0);
        check("mid_rsp_id", 32'(rsp_id_o), 0);
        check("mid_rsp_valid", 32'(rsp_valid_o), 0);
        tick();
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_no_rsp", 32'(rsp_valid_o), 0);
        end
        set_req(0, 8'h44, 8'h11, AluAdd);
        req_valid_i = 2'b11;
        #1;
        check("mid_post_grant0", 32'(req_ready_o), 32'h1);
        tick();
        req_valid_i = 2'b00;
        tick();
        check("mid_post_result", 32'(rsp_result_o), 32'h55);
        tick();

        // Idle hold
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_busy", 32'(busy_o), 0);
            check("idle_ready", 32'(req_ready_o), 0);
            check("idle_alu_a", 32'(alu_a_o), 32'h44);
            check("idle_alu_b", 32'(alu_b_o), 32'h11);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
